uart_mux: RTL and testbench
===========================

UART_MUX -- requirements
Module: uart_mux

Interface
REQ-001 SHALL have parameter FREQ, default 32_250_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 921600, meaning the UART bit rate; BAUDRATE <= FREQ/10.
REQ-003 SHALL have parameter DEPTH, default 8, meaning the packet FIFO depth; it is a power of two.
REQ-004 clk  in  1  single clock; all logic is on its rising edge.
REQ-005 resetn  in  1  reset, asynchronous, active-low.
REQ-006 addr  in  8  packet address byte (channel, same numbering as the host-to-board demux).
REQ-007 data  in  8  packet data byte.
REQ-008 write  in  1  enqueue request for {addr,data}, sampled each clk.
REQ-009 full  out  1  FIFO holds DEPTH packets.
REQ-010 overflow  out  1  one-cycle pulse when a write is dropped.
REQ-011 busy  out  1  FIFO non-empty or transmitter not IDLE.
REQ-012 uart_txd  out  1  serial line, idle high.

Function
REQ-013 Bit period DIV SHALL be (FREQ + BAUDRATE/2) / BAUDRATE clk cycles, using integer division (35 at defaults).
REQ-014 Byte framing SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each DIV cycles.
REQ-015 A packet SHALL be two bytes: addr first, then data, with no gap between them (the addr stop bit lasts exactly DIV cycles).
REQ-016 The FIFO SHALL be 16 bits wide and DEPTH entries deep, with a count register of log2(DEPTH)+1 bits.
REQ-017 write with full=0 SHALL store the packet at that edge.
REQ-018 write with full=1 SHALL drop the packet, leave the FIFO unchanged, and pulse overflow high on the next cycle.
- This holds even if a pop occurs in the same cycle: full is evaluated from the registered count.
REQ-019 Simultaneous write and pop with full=0 SHALL both take effect, leaving the count unchanged.
REQ-020 The transmitter FSM SHALL have states IDLE, START, BITS, STOP, plus a byte-select flag (ADDR/DATA).
REQ-021 IDLE SHALL behave as follows:
- If the FIFO is non-empty at an edge: pop the head, load the addr shift register, drive uart_txd=0, go to START, select ADDR.
- Otherwise: hold uart_txd=1.
REQ-022 START SHALL last DIV cycles, then go to BITS with uart_txd = bit0.
REQ-023 BITS SHALL shift one bit every DIV cycles; after bit7's period it SHALL go to STOP with uart_txd=1.
REQ-024 At the end of STOP:
- With ADDR selected: load the data byte, drive uart_txd=0, enter START, select DATA.
- With DATA selected: go to IDLE.
REQ-025 Latency: a write accepted at edge N into an empty FIFO with the FSM in IDLE SHALL drive uart_txd low from edge N+1.
REQ-026 Back-to-back packets SHALL have a final stop bit of DIV+1 cycles (one IDLE cycle), giving a packet period of 20*DIV+1 cycles (701 at defaults).
REQ-027 The baud counter SHALL reload to DIV-1 on every bit boundary and count down to 0; no fractional accumulation.
REQ-028 The popped packet SHALL be held in a local register, so FIFO writes during transmission do not alter the bytes in flight.
REQ-029 uart_txd SHALL be driven directly from a flop (glitch-free).
REQ-030 busy SHALL be combinational from the count and state; full SHALL be registered-count based.

Reset
REQ-031 resetn low SHALL asynchronously set: FSM=IDLE, FIFO count/pointers=0, uart_txd=1, overflow=0, full=0, busy=0, baud counter=0.
REQ-032 Reset asserted mid-byte SHALL abort the transmission: uart_txd=1 immediately, and queued packets are discarded.
REQ-033 After resetn rises, no transmission SHALL start until a new write.

Verification
REQ-034 Defaults; write {addr=8'h35,data=8'hA5} once.
- uart_txd low at N+1.
- Decoded bytes are 0x35 then 0xA5, each bit 35 cycles.
- Line high after 700 cycles; busy falls then.
REQ-035 Write 3 packets on consecutive cycles.
- All three sent in order.
- Packet starts spaced exactly 701 cycles apart.
REQ-036 With transmission stalled on the first packet, write DEPTH+1=9 more packets.
- full=1 after the 8th queued.
- The 9th is dropped, with an overflow pulse of exactly 1 cycle.
- 9 packets are transmitted in total (1 in flight + 8 queued).
REQ-037 full=1 while write is asserted on the same edge as an IDLE pop.
- Packet dropped, overflow pulses, count becomes DEPTH-1.
REQ-038 Assert resetn=0 during bit3 of the data byte.
- uart_txd=1 asynchronously, busy=0.
- After release, the line stays high until the next write.
REQ-039 Loopback through the existing UART demux at FREQ=32_250_000, BAUDRATE=921600, sending 256 random packets.
- Demux reports each addr/data pair in order, with uart_error never set.

Source files
------------

// File: rtl/uart_mux.sv
// uart_mux: board-to-host UART packet transmitter.
// Packets of {addr, data} are queued in a DEPTH-entry FIFO and sent as two
// back-to-back 8N1 bytes (addr first, then data) at BAUDRATE.
//
// Ports
//   clk       single clock, rising edge
//   resetn    asynchronous active-low reset
//   addr      packet address byte (channel number)
//   data      packet data byte
//   write     enqueue request for {addr,data}, sampled each clk
//   full      FIFO holds DEPTH packets (from the registered count)
//   overflow  one-cycle pulse after a write was dropped because FIFO was full
//   busy      FIFO non-empty or transmitter active
//   uart_txd  serial line, idle high, driven from a flop
module uart_mux #(
  parameter int unsigned FREQ     = 32_250_000,
  parameter int unsigned BAUDRATE = 921600,
  parameter int unsigned DEPTH    = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  input  logic       write,
  output logic       full,
  output logic       overflow,
  output logic       busy,
  output logic       uart_txd
);

  // Bit period in clk cycles, rounded to nearest.
  localparam int unsigned DIV = (FREQ + BAUDRATE / 2) / BAUDRATE;
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    BITS,
    STOP
  } tx_state_t;

  typedef enum logic {
    SEL_ADDR,
    SEL_DATA
  } byte_sel_t;

  // ---------------------------------------------------------------------
  // Packet FIFO
  // ---------------------------------------------------------------------
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   head;
  logic          push;
  logic          pop;

  assign full = (count == CW'(DEPTH));
  // A write while full is dropped even if a pop happens on the same edge.
  assign push = write & ~full;
  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {addr, data};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow <= write & full;
    end
  end

  // ---------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------
  tx_state_t     state, state_n;
  byte_sel_t     sel, sel_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    hold, hold_n;     // data byte of the packet in flight
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [BW-1:0] baud_cnt, baud_cnt_n;
  logic          txd_q, txd_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      sel      <= SEL_ADDR;
      shreg    <= '0;
      hold     <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      txd_q    <= 1'b1;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      shreg    <= shreg_n;
      hold     <= hold_n;
      bit_cnt  <= bit_cnt_n;
      baud_cnt <= baud_cnt_n;
      txd_q    <= txd_n;
    end
  end

  always_comb begin
    state_n    = state;
    sel_n      = sel;
    shreg_n    = shreg;
    hold_n     = hold;
    bit_cnt_n  = bit_cnt;
    baud_cnt_n = baud_cnt;
    txd_n      = txd_q;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (count != '0) begin
          pop        = 1'b1;
          shreg_n    = head[15:8];
          hold_n     = head[7:0];
          txd_n      = 1'b0;
          sel_n      = SEL_ADDR;
          baud_cnt_n = BAUD_RELOAD;
          state_n    = START;
        end
      end

      START: begin
        if (baud_cnt == '0) begin
          txd_n      = shreg[0];
          bit_cnt_n  = '0;
          baud_cnt_n = BAUD_RELOAD;
          state_n    = BITS;
        end else begin
          baud_cnt_n = baud_cnt - BW'(1);
        end
      end

      BITS: begin
        if (baud_cnt == '0) begin
          baud_cnt_n = BAUD_RELOAD;
          if (bit_cnt == 3'd7) begin
            txd_n   = 1'b1;
            state_n = STOP;
          end else begin
            // Line already shows shreg[0]; advance to the next bit.
            shreg_n   = shreg >> 1;
            txd_n     = shreg[1];
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt - BW'(1);
        end
      end

      STOP: begin
        if (baud_cnt == '0) begin
          if (sel == SEL_ADDR) begin
            // Data byte follows the addr stop bit with no gap.
            shreg_n    = hold;
            txd_n      = 1'b0;
            sel_n      = SEL_DATA;
            baud_cnt_n = BAUD_RELOAD;
            state_n    = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt - BW'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign uart_txd = txd_q;
  assign busy     = (count != '0) || (state != IDLE);

endmodule

// File: tb/tb_uart_mux.sv
// tb_uart_mux: randomized scoreboard bench for uart_mux.
// A packet-level model predicts acceptance, drops, overflow, full, busy and
// the edge at which each packet starts; a serial decoder rebuilds frames
// from uart_txd and compares them with the expected queues.
module tb_uart_mux;

  localparam int FREQ     = 32_250_000;
  localparam int BAUDRATE = 921600;
  localparam int DEPTH    = 8;
  localparam int DIV      = (FREQ + BAUDRATE / 2) / BAUDRATE;
  localparam int PKT      = 20 * DIV;

  logic       clk;
  logic       resetn;
  logic [7:0] addr;
  logic [7:0] data;
  logic       write;
  logic       full;
  logic       overflow;
  logic       busy;
  logic       uart_txd;

  uart_mux #(
    .FREQ(FREQ),
    .BAUDRATE(BAUDRATE),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .addr(addr),
    .data(data),
    .write(write),
    .full(full),
    .overflow(overflow),
    .busy(busy),
    .uart_txd(uart_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, got, want, edge_no);
    end
  endtask

  // ---------------------------------------------------------------------
  // Packet-level reference model (runs at every rising edge)
  // ---------------------------------------------------------------------
  int          edge_no   = 0;
  logic [15:0] fifo_m[$];
  logic [15:0] exp_pkt[$];
  int          exp_start[$];
  bit          have_pop  = 0;
  int          last_pop  = 0;
  int          next_free = 0;
  bit          ovf_m     = 0;

  function automatic bit tx_active();
    return have_pop && (edge_no < last_pop + PKT);
  endfunction

  always @(posedge clk) begin
    int cnt_pre;
    edge_no++;
    if (!resetn) begin
      fifo_m.delete();
      exp_pkt.delete();
      exp_start.delete();
      have_pop  = 0;
      next_free = 0;
      ovf_m     = 0;
    end else begin
      cnt_pre = fifo_m.size();
      ovf_m   = write && (cnt_pre == DEPTH);
      // One packet occupies the line for 20 bit periods; the transmitter
      // then spends one cycle idle before it can take the next one.
      if (cnt_pre > 0 && edge_no >= next_free) begin
        void'(fifo_m.pop_front());
        exp_start.push_back(edge_no);
        last_pop  = edge_no;
        have_pop  = 1;
        next_free = edge_no + PKT + 1;
      end
      if (write && cnt_pre != DEPTH) begin
        fifo_m.push_back({addr, data});
        exp_pkt.push_back({addr, data});
      end
    end
  end

  // Cycle-level status checks, sampled on the falling edge.
  always @(negedge clk) begin
    if (resetn) begin
      chk("full", full, (fifo_m.size() == DEPTH));
      chk("overflow", overflow, ovf_m);
      chk("busy", busy, (fifo_m.size() > 0) || tx_active());
      if (!tx_active()) chk("idle_line", uart_txd, 1'b1);
    end
  end

  // ---------------------------------------------------------------------
  // Serial decoder / scoreboard monitor
  // ---------------------------------------------------------------------
  bit          dec_active = 0;
  int          dec_start  = 0;
  logic [19:0] s_first, s_mid, s_last;

  always @(negedge clk) begin
    int off, slot, pos;
    bit frame_ok;
    logic [15:0] got, want;
    if (!resetn) begin
      dec_active = 0;
    end else begin
      if (!dec_active && uart_txd == 1'b0) begin
        dec_active = 1;
        dec_start  = edge_no;
      end
      if (dec_active) begin
        off  = edge_no - dec_start;
        slot = off / DIV;
        pos  = off % DIV;
        if (pos == 0)       s_first[slot] = uart_txd;
        if (pos == DIV / 2) s_mid[slot]   = uart_txd;
        if (pos == DIV - 1) s_last[slot]  = uart_txd;
        if (off == PKT - 1) begin
          dec_active = 0;
          // Each bit must hold its level for the whole period.
          frame_ok = (s_first == s_mid) && (s_mid == s_last) &&
                     !s_mid[0] && s_mid[9] && !s_mid[10] && s_mid[19];
          chk("frame_timing", frame_ok, 1'b1);
          got = {s_mid[8:1], s_mid[18:11]};
          if (exp_pkt.size() == 0) begin
            chk("unexpected_packet", got, 16'hxxxx);
          end else begin
            want = exp_pkt.pop_front();
            chk("packet", got, want);
          end
          if (exp_start.size() == 0) begin
            chk("unexpected_start", dec_start, 0);
          end else begin
            chk("start_cycle", dec_start, exp_start.pop_front());
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [7:0] a, input logic [7:0] d);
    write = 1'b1;
    addr  = a;
    data  = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic put_rand();
    put(8'($urandom), 8'($urandom));
  endtask

  initial begin
    bit drained;
    resetn = 1'b0;
    write  = 1'b0;
    addr   = '0;
    data   = '0;
    repeat (3) @(negedge clk);
    chk("reset_txd", uart_txd, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_full", full, 1'b0);
    chk("reset_overflow", overflow, 1'b0);
    resetn = 1'b1;
    cycles(5);

    // Single packet, then the line must be idle again.
    put(8'h35, 8'hA5);
    cycles(PKT + 5);
    chk("busy_after_single", busy, 1'b0);

    // Three packets on consecutive cycles.
    for (int i = 0; i < 3; i++) put_rand();
    cycles(3 * (PKT + 1) + 10);

    // Stall on one packet in flight, then push DEPTH+1 more.
    put_rand();
    cycles(3);
    for (int i = 0; i < DEPTH + 1; i++) put_rand();
    chk("overflow_pulse", overflow, 1'b1);
    chk("full_after_fill", full, 1'b1);
    @(negedge clk);
    chk("overflow_single_cycle", overflow, 1'b0);

    // Hold write across the next pop: the write on the pop edge is dropped.
    write = 1'b1;
    for (int i = 0; i < PKT + 20; i++) begin
      addr = 8'($urandom);
      data = 8'($urandom);
      @(negedge clk);
    end
    write = 1'b0;
    cycles((DEPTH + 1) * (PKT + 1) + 50);

    // Reset during bit3 of the data byte.
    put_rand();
    cycles(1 + 14 * DIV + 10);
    #3 resetn = 1'b0;
    #1;
    chk("async_reset_txd", uart_txd, 1'b1);
    chk("async_reset_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    cycles(50);
    put_rand();
    cycles(PKT + 10);

    // Random traffic: bursts and gaps.
    for (int i = 0; i < 30; i++) begin
      put_rand();
      if ($urandom_range(0, 2) == 0) cycles($urandom_range(0, 3));
      else cycles($urandom_range(300, 900));
    end

    drained = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (exp_pkt.size() == 0 && !busy && !dec_active) begin
        drained = 1;
        break;
      end
    end
    chk("drain_done", drained, 1'b1);
    chk("left_in_scoreboard", exp_pkt.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: got timeout want completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
